// File: rtl/simplebus_imem_responder.sv
// simplebus_imem_responder: SimpleBus fetch responder returning one word from a preloadable array after LATENCY cycles.
// Define SIMPLEBUS_IMEM_RAND_DELAY_EN to add 0..7 LFSR-chosen extra wait cycles per request.
module simplebus_imem_responder #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] req_addr,
  input  logic        req_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic        busy,
  output logic        overrun,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] addr_q, rd_addr;
  logic [4:0] cnt, cnt_init;
  logic [2:0] extra;
  function automatic logic hit(input logic [31:0] a);
    return {1'b0, a} >= {1'b0, BASE_ADDR} && {1'b0, a} < {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
  endfunction
  function automatic logic [AW-1:0] idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction
`ifdef SIMPLEBUS_IMEM_RAND_DELAY_EN
  logic [7:0] lfsr;
  always_ff @(posedge clock or negedge reset)
    if (!reset) lfsr <= 8'hA5;
    else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign extra = lfsr[2:0];
`else
  assign extra = '0;
`endif
  // One counter covers base latency plus any extra delay; zero means skip WAIT.
  assign cnt_init = 5'(LATENCY - 1) + 5'(extra);
  assign rd_addr = state == IDLE ? req_addr : addr_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      addr_q <= '0;
      cnt <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      overrun <= overrun | (req_valid && state != IDLE);
      if (state == IDLE && req_valid) begin
        addr_q <= req_addr;
        cnt <= cnt_init;
      end else if (state == WAIT) cnt <= cnt - 5'd1;
      if (state_nx == RESP) begin
        resp_rdata <= hit(rd_addr) ? mem[idx(rd_addr)] : '0;
        resp_err <= !hit(rd_addr);
      end
    end
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE) state_nx = req_valid ? (cnt_init == 5'd0 ? RESP : WAIT) : IDLE;
    else if (state == WAIT) state_nx = cnt == 5'd1 ? RESP : WAIT;
  end
  always_comb begin
    resp_valid = state == RESP;
    busy = state != IDLE;
  end
  always_ff @(posedge clock)
    if (load_en && hit(load_addr)) mem[idx(load_addr)] <= load_data;
endmodule

// File: tb/tb_simplebus_imem_responder.sv
// tb_simplebus_imem_responder: table, directed and random checks against a flat-array memory model.
module tb_simplebus_imem_responder;
  localparam int          LATENCY = 2;
  localparam int          DEPTH   = 4096;
  localparam logic [31:0] BASE    = 32'h8000_0000;
  logic clock, reset, req_valid, resp_valid, resp_err, busy, overrun, load_en;
  logic [31:0] req_addr, resp_rdata, load_addr, load_data;
  simplebus_imem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LATENCY)) dut (
    .clock(clock), .reset(reset), .req_addr(req_addr), .req_valid(req_valid),
    .resp_rdata(resp_rdata), .resp_valid(resp_valid), .resp_err(resp_err), .busy(busy),
    .overrun(overrun), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );
  initial clock = 0;
  always #5 clock = ~clock;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;
  vec_t tv [8];
  int vecs = 0, miss = 0;
  logic [31:0] mm [DEPTH];
  bit seen [64];
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  function automatic bit in_rng(input logic [31:0] a);
    return 64'(a) >= 64'(BASE) && 64'(a) < 64'(BASE) + 64'(4 * DEPTH);
  endfunction
  function automatic logic [31:0] mdl(input logic [31:0] a);
    return in_rng(a) ? mm[int'((a - BASE) >> 2)] : 32'h0;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask
  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1;
    load_addr = a;
    load_data = d;
    tick;
    load_en = 0;
    if (in_rng(a)) mm[int'((a - BASE) >> 2)] = d;
  endtask
  task automatic do_req(input logic [31:0] a, input logic [31:0] ed, input logic ee, input string n, output int lat);
    logic [31:0] d;
    req_addr = a;
    req_valid = 1;
    tick;
    req_valid = 0;
    chk({n, "_busy"}, 32'(busy), 1);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      tick;
      lat++;
    end
    chk({n, "_resp_seen"}, 32'(resp_valid), 1);
    d = resp_rdata;
    chk({n, "_data"}, resp_rdata, ed);
    chk({n, "_err"}, 32'(resp_err), 32'(ee));
`ifdef SIMPLEBUS_IMEM_RAND_DELAY_EN
    chk({n, "_lat_range"}, 32'(lat >= LATENCY && lat <= LATENCY + 7), 1);
`else
    chk({n, "_lat"}, lat, LATENCY);
`endif
    tick;
    chk({n, "_pulse_end"}, 32'(resp_valid), 0);
    chk({n, "_busy_end"}, 32'(busy), 0);
    chk({n, "_hold"}, resp_rdata, d);
  endtask
  initial begin
    int lat, n, ndist;
    logic [31:0] a, d;
    logic got;
    reset = 0;
    req_valid = 0;
    req_addr = 0;
    load_en = 0;
    load_addr = 0;
    load_data = 0;
    repeat (3) tick;
    chk("rst_valid", 32'(resp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_err", 32'(resp_err), 0);
    chk("rst_rdata", resp_rdata, 0);
    reset = 1;
    tick;
    for (int i = 0; i < 64; i++) do_load(BASE + 32'(4 * i), $urandom);
    do_load(BASE, 32'h0000_0413);
    do_load(BASE + 32'h14, 32'h0010_0093);
    do_load(BASE + 32'h3FFC, 32'hDEAD_BEEF);
    do_load(BASE + 32'h4000, 32'h1234_5678);
    tv[0] = '{32'h8000_0014, 32'h0010_0093, 1'b0};
    tv[1] = '{32'h8000_4000, 32'h0000_0000, 1'b1};
    tv[2] = '{32'h8000_0003, 32'h0000_0413, 1'b0};
    tv[3] = '{32'h8000_3FFC, 32'hDEAD_BEEF, 1'b0};
    tv[4] = '{32'h8000_0016, 32'h0010_0093, 1'b0};
    tv[5] = '{32'h7FFF_FFFC, 32'h0000_0000, 1'b1};
    tv[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1};
    tv[7] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
    for (int i = 0; i < 8; i++) do_req(tv[i].addr, tv[i].data, tv[i].err, $sformatf("tv%0d", i), lat);
    chk("overrun_clear", 32'(overrun), 0);
    n = 0;
    d = 0;
    req_addr = BASE;
    req_valid = 1;
    tick;
    req_addr = BASE + 32'h14;
    req_valid = 1;
    for (int c = 0; c < 20; c++) begin
      if (resp_valid) begin
        n++;
        d = resp_rdata;
      end
      tick;
      req_valid = 0;
    end
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_pulses", n, 1);
    chk("ovr_data", d, 32'h0000_0413);
    do_req(BASE + 32'h14, 32'h0010_0093, 1'b0, "b2b_a", lat);
    do_req(BASE + 32'h4, mm[1], 1'b0, "b2b_b", lat);
    chk("ovr_sticky", 32'(overrun), 1);
    a = BASE + 32'h1C;
    d = mm[7];
    got = 0;
    req_addr = a;
    req_valid = 1;
    for (int c = 0; c < 20; c++) begin
      load_en = (c == LATENCY - 1);
      load_addr = a;
      load_data = ~d;
      tick;
      req_valid = 0;
      load_en = 0;
      if (resp_valid && !got) begin
        got = 1;
`ifndef SIMPLEBUS_IMEM_RAND_DELAY_EN
        chk("rbw_old", resp_rdata, d);
`endif
      end
    end
    chk("rbw_seen", 32'(got), 1);
    mm[7] = ~d;
    do_req(a, ~d, 1'b0, "rbw_new", lat);
    do_req(BASE + 32'h14, 32'h0010_0093, 1'b0, "pre_rst", lat);
    req_addr = BASE + 32'h24;
    req_valid = 1;
    tick;
    req_valid = 0;
    reset = 0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rdata", resp_rdata, 0);
    chk("mid_rst_valid", 32'(resp_valid), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    tick;
    reset = 1;
    n = 0;
    repeat (20) begin
      tick;
      n += int'(resp_valid);
    end
    chk("mid_rst_no_resp", n, 0);
    chk("mid_rst_busy_after", 32'(busy), 0);
    do_req(BASE, 32'h0000_0413, 1'b0, "post_rst", lat);
    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(0, 9) < 3) do_load($urandom_range(0, 4) == 0 ? BASE - 4 : BASE + 32'(4 * $urandom_range(0, 63)), $urandom);
      case ($urandom_range(0, 4))
        0: a = BASE + 32'h4000 + 32'($urandom_range(0, 255));
        1: a = BASE - 1 - 32'($urandom_range(0, 255));
        default: a = BASE + 32'($urandom_range(0, 255));
      endcase
      do_req(a, mdl(a), !in_rng(a), $sformatf("rand%0d", i), lat);
      if (lat > 0 && lat < 64) seen[lat] = 1;
    end
    ndist = 0;
    for (int i = 0; i < 64; i++) ndist += int'(seen[i]);
`ifdef SIMPLEBUS_IMEM_RAND_DELAY_EN
    chk("rand_distinct_lat", 32'(ndist >= 2), 1);
`else
    chk("fixed_single_lat", ndist, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
